pipe_stage_reg: RTL
===================

// Module: pipe_stage_reg
// PURPOSE
//   Parametrised elastic inter-stage pipeline register for the pipelined CPU (ID/EX, EX/MEM, MEM/WB).
//   Carries a DATA_W operand payload and a CTRL_W control bundle through STAGES slots.
//   Adds valid/ready backpressure and a per-slot valid bit. Flush turns every held slot into a bubble.
// PARAMETERS
//   DATA_W     256     payload width in bits (pc, rs data, imm, rd, func fields)
//   CTRL_W     16      control-bundle width (RegWrite, MemWrite, Branch, ...)
//   STAGES     1       number of chained register slots, 1..4
//   CTRL_BUB   '0      CTRL_W value driven for an empty/flushed slot
// PORTS
//   clk        in   1        clock
//   reset      in   1        synchronous, active-high reset
//   flush      in   1        kill all held slots and the current input beat
//   in_valid   in   1        upstream beat present
//   in_ready   out  1        stage accepts a beat this cycle
//   in_data    in   DATA_W   upstream payload
//   in_ctrl    in   CTRL_W   upstream control bundle
//   out_valid  out  1        downstream beat present
//   out_ready  in   1        downstream accepts a beat
//   out_data   out  DATA_W   payload of the head slot
//   out_ctrl   out  CTRL_W   control of the head slot; CTRL_BUB when out_valid=0
//   kill_cnt   out  8        saturating count of valid beats discarded by flush
// BEHAVIOUR
//   - Clock is clk. Reset is synchronous and active-high on reset; all state updates on posedge clk.
//   - Reset values: every slot valid=0, data=0, ctrl=CTRL_BUB. out_valid=0, out_data=0, out_ctrl=CTRL_BUB, kill_cnt=0.
//   - Transfer: an input beat is accepted when in_valid&&in_ready. An output beat is consumed when out_valid&&out_ready.
//   - Latency: an accepted beat reaches out_valid after STAGES cycles when nothing downstream is stalled. Throughput is 1 beat/cycle.
//   - Each slot loads from its predecessor when it is empty or when its own content moves on the same cycle (bubble collapse).
//   - Payload and ctrl for each beat move together. The order of beats is never changed.
//   - flush=1 for a cycle: on the next edge all slot valid bits go to 0 and every ctrl goes to CTRL_BUB. data keeps its value (don't-care).
//     A beat with in_valid=1 in that cycle is discarded, not accepted. kill_cnt increases by the number of valid slots plus the discarded input beat.
//     Flush takes precedence over acceptance and over consumption in the same cycle.
//   - kill_cnt saturates at 255 and is cleared only by reset.
//   - Reset asserted during traffic: the reset state applies at the next edge, and reset takes precedence over flush.
//   - out_ctrl is forced to CTRL_BUB whenever the head slot is invalid. Downstream control bits therefore never fire on bubbles.
// CONFIGURATION
//   PIPE_SKID_EN defined:
//     - Each slot gets a 1-entry skid buffer, and in_ready is a registered signal.
//     - in_ready = !skid_full, so there is no combinational path from out_ready to in_ready.
//     - Flush also clears the skid buffers.
//   PIPE_SKID_EN undefined:
//     - in_ready = !slot0_valid || slot0_advances, which is combinational back through the chain to out_ready.
//     - There are no skid registers.
// STRUCTURE
//   - Shared package cpu_pipe_pkg holds the ctrl-bundle field offsets (CTRL_REGWRITE, CTRL_MEMWRITE, ...) and the CTRL_BUB constant.
//   - Sub-module pipe_slot holds one valid/data/ctrl slot plus the optional skid entry. It is instantiated STAGES times in a generate loop.
//   - The top level holds the flush fan-out, the kill counter and the out_ctrl bubble mux.
// TESTING
//   1. Reset: assert reset for 2 cycles with in_valid=1.
//      -> out_valid=0, out_ctrl=CTRL_BUB, kill_cnt=0, and no beat is accepted.
//   2. Streaming with STAGES=2 and out_ready=1: send data 1..8 back to back.
//      -> out_valid first rises 2 cycles after the first beat; data 1..8 arrive in order on consecutive cycles.
//   3. Backpressure: hold out_ready=0 for 5 cycles mid-stream.
//      -> no beat is lost or duplicated; in_ready drops once all slots (and skids) are full; the stream resumes in order.
//   4. Flush with STAGES=2, both slots full and in_valid=1:
//      -> the next cycle has out_valid=0 and out_ctrl=CTRL_BUB; kill_cnt goes from 0 to 3.
//   5. Flush and consume together: out_ready=1 and flush=1 in the same cycle.
//      -> the head beat is killed, not delivered, and kill_cnt counts it.
//   6. Saturation: issue 300 flushes, each with in_valid=1.
//      -> kill_cnt ends at 255; with PIPE_SKID_EN, in_ready shows no same-cycle dependence on out_ready.

Source files
------------

// File: rtl/cpu_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cpu_pipe_pkg
// Brief   : Control-bundle field offsets, bubble constant and kill-count helper.
// Rev     : 1.0
// ============================================================================
package cpu_pipe_pkg;

  localparam int CTRL_W_DEFAULT = 16;

  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMWRITE = 1;
  localparam int CTRL_MEMREAD  = 2;
  localparam int CTRL_BRANCH   = 3;
  localparam int CTRL_JUMP     = 4;
  localparam int CTRL_ALUSRC   = 5;
  localparam int CTRL_MEMTOREG = 6;

  localparam logic [CTRL_W_DEFAULT-1:0] CTRL_BUB = '0;

  localparam int KILL_W = 8;

  function automatic logic [KILL_W-1:0] kill_sat_add(input logic [KILL_W-1:0] cnt,
                                                     input logic [3:0]        inc);
    logic [KILL_W:0] sum;
    sum = {1'b0, cnt} + {{(KILL_W-3){1'b0}}, inc};
    return sum[KILL_W] ? {KILL_W{1'b1}} : sum[KILL_W-1:0];
  endfunction

endpackage : cpu_pipe_pkg
`default_nettype wire

// File: rtl/pipe_slot.sv
`default_nettype none
// ============================================================================
// Module  : pipe_slot
// Brief   : One valid/data/ctrl pipeline slot; with PIPE_SKID_EN a 1-entry
//           skid buffer is added and upstream ready becomes registered.
// Rev     : 1.0
// ============================================================================
module pipe_slot #(
  parameter int                DATA_W   = 256,
  parameter int                CTRL_W   = 16,
  parameter logic [CTRL_W-1:0] CTRL_BUB = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              i_up_valid,
  input  logic [DATA_W-1:0] i_up_data,
  input  logic [CTRL_W-1:0] i_up_ctrl,
  output logic              o_dn_valid,
  output logic [DATA_W-1:0] o_dn_data,
  output logic [CTRL_W-1:0] o_dn_ctrl,
  input  logic              i_dn_ready,
`ifdef PIPE_SKID_EN
  output logic              o_up_ready,
`endif
  output logic [1:0]        o_held
);
  import cpu_pipe_pkg::*;

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [CTRL_W-1:0] r_ctrl;
  logic              w_main_free;

  // Main register may take a new beat when empty or when its beat leaves now.
  assign w_main_free = !r_valid || i_dn_ready;

`ifdef PIPE_SKID_EN
  logic              r_skid_valid;
  logic [DATA_W-1:0] r_skid_data;
  logic [CTRL_W-1:0] r_skid_ctrl;

  assign o_up_ready = !r_skid_valid;
  assign o_held     = {r_valid & r_skid_valid, r_valid ^ r_skid_valid};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid      <= 1'b0;
      r_data       <= '0;
      r_ctrl       <= CTRL_BUB;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_ctrl  <= CTRL_BUB;
    end else if (flush) begin
      r_valid      <= 1'b0;
      r_ctrl       <= CTRL_BUB;
      r_skid_valid <= 1'b0;
      r_skid_ctrl  <= CTRL_BUB;
    end else if (r_skid_valid) begin
      if (w_main_free) begin
        r_valid      <= 1'b1;
        r_data       <= r_skid_data;
        r_ctrl       <= r_skid_ctrl;
        r_skid_valid <= 1'b0;
        r_skid_ctrl  <= CTRL_BUB;
      end
    end else if (i_up_valid) begin
      if (w_main_free) begin
        r_valid <= 1'b1;
        r_data  <= i_up_data;
        r_ctrl  <= i_up_ctrl;
      end else begin
        r_skid_valid <= 1'b1;
        r_skid_data  <= i_up_data;
        r_skid_ctrl  <= i_up_ctrl;
      end
    end else if (w_main_free) begin
      r_valid <= 1'b0;
      r_ctrl  <= CTRL_BUB;
    end
  end
`else
  assign o_held = {1'b0, r_valid};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ctrl  <= CTRL_BUB;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_ctrl  <= CTRL_BUB;
    end else if (w_main_free) begin
      r_valid <= i_up_valid;
      if (i_up_valid) begin
        r_data <= i_up_data;
        r_ctrl <= i_up_ctrl;
      end else begin
        r_ctrl <= CTRL_BUB;
      end
    end
  end
`endif

  assign o_dn_valid = r_valid;
  assign o_dn_data  = r_data;
  assign o_dn_ctrl  = r_ctrl;

endmodule : pipe_slot
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module  : pipe_stage_reg
// Brief   : Elastic inter-stage pipeline register (STAGES slots) with flush,
//           saturating kill counter and bubble-forced control output.
//           Optional skid buffers / registered in_ready via PIPE_SKID_EN.
// Rev     : 1.0
// ============================================================================
module pipe_stage_reg #(
  parameter int                DATA_W   = 256,
  parameter int                CTRL_W   = 16,
  parameter int                STAGES   = 1,
  parameter logic [CTRL_W-1:0] CTRL_BUB = CTRL_W'(cpu_pipe_pkg::CTRL_BUB)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [7:0]        kill_cnt
);
  import cpu_pipe_pkg::*;

  logic              w_valid [STAGES+1];
  logic [DATA_W-1:0] w_data  [STAGES+1];
  logic [CTRL_W-1:0] w_ctrl  [STAGES+1];
  logic              w_ready [STAGES+1];
  logic [1:0]        w_held  [STAGES];
  logic [3:0]        w_kill_inc;
  logic [7:0]        r_kill_cnt;

  assign w_valid[0] = in_valid;
  assign w_data[0]  = in_data;
  assign w_ctrl[0]  = in_ctrl;

  generate
    for (genvar g = 0; g < STAGES; g++) begin : g_slot
      pipe_slot #(
        .DATA_W   (DATA_W),
        .CTRL_W   (CTRL_W),
        .CTRL_BUB (CTRL_BUB)
      ) u_slot (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .i_up_valid (w_valid[g]),
        .i_up_data  (w_data[g]),
        .i_up_ctrl  (w_ctrl[g]),
        .o_dn_valid (w_valid[g+1]),
        .o_dn_data  (w_data[g+1]),
        .o_dn_ctrl  (w_ctrl[g+1]),
        .i_dn_ready (w_ready[g+1]),
`ifdef PIPE_SKID_EN
        .o_up_ready (w_ready[g]),
`endif
        .o_held     (w_held[g])
      );
    end
  endgenerate

`ifdef PIPE_SKID_EN
  assign w_ready[STAGES] = out_ready;
`else
  // Ready ripples back from the head: a slot frees when empty or when its beat moves on.
  always_comb begin
    w_ready[STAGES] = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      w_ready[i] = !w_valid[i+1] || w_ready[i+1];
    end
  end
`endif

  assign in_ready = w_ready[0];

  always_comb begin
    w_kill_inc = {3'b000, in_valid};
    for (int i = 0; i < STAGES; i++) begin
      w_kill_inc = w_kill_inc + {2'b00, w_held[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_kill_cnt <= '0;
    end else if (flush) begin
      r_kill_cnt <= kill_sat_add(r_kill_cnt, w_kill_inc);
    end
  end

  assign kill_cnt  = r_kill_cnt;
  assign out_valid = w_valid[STAGES];
  assign out_data  = w_data[STAGES];
  assign out_ctrl  = w_valid[STAGES] ? w_ctrl[STAGES] : CTRL_BUB;

endmodule : pipe_stage_reg
`default_nettype wire
